if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  IF stage: owns the PC, drives the instruction-memory (I-cache) read handshake, holds a returned
//  instruction while the pipeline is stalled, and applies branch/jump redirects. Feeds the IF/ID
//  pipeline register (PC_IF, INSTRUCTION_IF, FETCH_BUSY -> that register's IMEM_BUSYWAIT input).
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  PC_STEP    4              PC increment per accepted instruction
// PORTS
//  CLK            in   1   clock, all state on rising edge
//  RESET_N        in   1   asynchronous, active-low reset
//  HOLD           in   1   hazard-unit stall; IF/ID will not capture this cycle
//  MEM_BUSYWAIT   in   1   data-memory stall; IF/ID will not capture this cycle
//  BRANCH_TAKEN   in   1   redirect request from EX
//  BRANCH_TARGET  in   32  redirect address
//  IMEM_READ      out  1   I-mem read request
//  IMEM_ADDR      out  32  I-mem word address (stable while IMEM_READ && IMEM_BUSYWAIT)
//  IMEM_READDATA  in   32  I-mem data, valid when IMEM_READ && !IMEM_BUSYWAIT
//  IMEM_BUSYWAIT  in   1   I-mem not ready
//  PC_IF          out  32  PC of INSTRUCTION_IF
//  INSTRUCTION_IF out  32  fetched instruction, 32'h0 when IF_VALID=0
//  IF_VALID       out  1   PC_IF/INSTRUCTION_IF are a real instruction this cycle
//  FETCH_BUSY     out  1   = !IF_VALID
//  FETCH_FAULT    out  1   misaligned-target fault (macro only, else tied 0)
// BEHAVIOUR
//  - advance = IF_VALID && !HOLD && !MEM_BUSYWAIT && !BRANCH_TAKEN; resp = IMEM_READ && !IMEM_BUSYWAIT.
//  - Registers: pc_q, req_addr_q, ibuf_q, state_q. Reset: state S_IDLE, pc_q=req_addr_q=RESET_PC,
//    ibuf_q=0, IMEM_READ=0, IMEM_ADDR=RESET_PC, PC_IF=RESET_PC, INSTRUCTION_IF=0, IF_VALID=0,
//    FETCH_BUSY=1, FETCH_FAULT=0.
//  - S_IDLE: no request; next edge -> S_FETCH (first request 1 cycle after reset release).
//  - S_FETCH: IMEM_READ=1, IMEM_ADDR=pc_q, req_addr_q<=pc_q. Outputs combinational from memory:
//    IF_VALID=resp, INSTRUCTION_IF=resp?IMEM_READDATA:0, PC_IF=pc_q. Hit latency 0 (same cycle).
//      resp && advance  -> pc_q<=pc_q+PC_STEP, stay S_FETCH (1 instr/cycle on hits).
//      resp && !advance && !BRANCH_TAKEN -> ibuf_q<=IMEM_READDATA, -> S_HELD.
//      !resp -> stay; address must not change.
//  - S_HELD: IMEM_READ=0; IF_VALID=1, INSTRUCTION_IF=ibuf_q, PC_IF=pc_q.
//      advance -> pc_q<=pc_q+PC_STEP, -> S_FETCH.
//  - S_KILL: IMEM_READ=1, IMEM_ADDR=req_addr_q (abandoned miss finishes), IF_VALID=0.
//      resp -> data discarded, -> S_FETCH (pc_q already holds target).
//  - Redirect (BRANCH_TAKEN, highest priority, any state but S_IDLE, regardless of HOLD/MEM_BUSYWAIT):
//    pc_q<=BRANCH_TARGET&~3; IF_VALID forced 0 that cycle; ibuf_q dropped.
//    From S_FETCH with !resp -> S_KILL; S_FETCH with resp, or S_HELD -> S_FETCH; S_KILL stays S_KILL.
//    BRANCH_TAKEN held several cycles re-loads the same target each cycle (idempotent).
//  - pc_q+PC_STEP wraps modulo 2^32 (32'hFFFF_FFFC -> 0), no flag.
//  - Reset mid-miss: request dropped immediately, IMEM_READ=0 while RESET_N=0; restart from RESET_PC.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: BRANCH_TAKEN with BRANCH_TARGET[1:0]!=0 sets sticky FETCH_FAULT,
//    state -> S_FAULT (no requests, IF_VALID=0) until reset; pc_q<=BRANCH_TARGET unmasked.
//  Undefined: target bits [1:0] silently cleared, FETCH_FAULT tied 0, no S_FAULT state.
// STRUCTURE
//  Package if_fetch_pkg: state encoding (S_IDLE,S_FETCH,S_HELD,S_KILL,S_FAULT), INSTR_BUBBLE=32'h0,
//    PC_ALIGN_MASK=32'hFFFF_FFFC.
//  One sub-module: if_fetch_fsm (state register + next-state/redirect logic); datapath regs in top.
// TESTING
//  1 Reset: RESET_N=0 -> IMEM_READ=0, PC_IF=0, IF_VALID=0; release -> IMEM_READ=1, ADDR=0 one cycle later.
//  2 Hit stream: IMEM_BUSYWAIT=0 -> PC_IF 0,4,8,12 on consecutive cycles, IF_VALID=1 each.
//  3 Miss: busywait 3 cycles at 0x8 -> ADDR stays 0x8, IF_VALID=0 x3, then instr at 0x8.
//  4 Stall: hit at 0x10 with HOLD=1 for 2 cycles -> IMEM_READ=0, INSTRUCTION_IF=buffered word,
//    PC_IF=0x10 throughout; HOLD=0 -> next ADDR=0x14.
//  5 Redirect during miss at 0x20, target 0x100 -> ADDR stays 0x20 until resp, data discarded
//    (IF_VALID=0), next ADDR=0x100; BRANCH_TAKEN held 3 cycles -> no extra fetches from stale PC.
//  6 Macro: target 0x102 -> FETCH_FAULT=1 sticky, IMEM_READ=0; without macro fetch at 0x100.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e  : fetch controller state encoding
//   INSTR_BUBBLE   : instruction word presented when no valid instruction
//   PC_ALIGN_MASK  : clears the byte-offset bits of a word address
//   align_pc()     : applies PC_ALIGN_MASK to an address
// ----------------------------------------------------------------------------
package if_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_HELD  = 3'd2,
    S_KILL  = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [31:0] INSTR_BUBBLE  = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_pc(input logic [31:0] i_addr);
    return i_addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_fsm.sv
// ----------------------------------------------------------------------------
// if_fetch_fsm
// State register and next-state logic of the fetch controller. The datapath
// (PC, request address, instruction buffer) lives in the top level; this block
// only decides where the controller goes next and whether a redirect is taken.
//
// Ports
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset
//   i_resp         I-mem read completed this cycle (read && !busywait)
//   i_advance      IF/ID accepts the presented instruction this cycle
//   i_branch_taken redirect request from EX
//   i_trap         redirect target is misaligned and trapping is enabled
//                  (only ever non-zero when FETCH_MISALIGN_TRAP_EN is defined)
//   o_state        current state
//   o_redirect     redirect is honoured this cycle (PC must load the target)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | just out of reset, no request yet
// S_FETCH | request at pc, instruction returned combinationally on a hit
// S_HELD  | returned instruction buffered while IF/ID is stalled
// S_KILL  | finishing an abandoned miss; its data is thrown away
// S_FAULT | misaligned redirect seen; fetch stopped until reset
// ----------------------------------------------------------------------------
module if_fetch_fsm
  import if_fetch_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_resp,
  input  logic         i_advance,
  input  logic         i_branch_taken,
  input  logic         i_trap,
  output fetch_state_e o_state,
  output logic         o_redirect
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic         w_redirect;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_redirect   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (i_branch_taken) begin
          w_redirect = 1'b1;
          // A miss in flight cannot be cancelled at the memory, so it is
          // allowed to complete in S_KILL before the target is requested.
          if (i_trap)      w_state_next = S_FAULT;
          else if (i_resp) w_state_next = S_FETCH;
          else             w_state_next = S_KILL;
        end else if (i_resp && !i_advance) begin
          w_state_next = S_HELD;
        end
      end
      S_HELD: begin
        if (i_branch_taken) begin
          w_redirect   = 1'b1;
          w_state_next = i_trap ? S_FAULT : S_FETCH;
        end else if (i_advance) begin
          w_state_next = S_FETCH;
        end
      end
      S_KILL: begin
        if (i_branch_taken) begin
          w_redirect   = 1'b1;
          w_state_next = i_trap ? S_FAULT : S_KILL;
        end else if (i_resp) begin
          w_state_next = S_FETCH;
        end
      end
      S_FAULT: begin
        w_state_next = S_FAULT;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_state    = r_state;
  assign o_redirect = w_redirect;

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage. Owns the PC, runs the I-mem read handshake, buffers
// a returned instruction while the pipeline is stalled and applies branch/jump
// redirects. Hits return in the same cycle, giving one instruction per cycle.
//
// Build option
//   FETCH_MISALIGN_TRAP_EN : when defined, a redirect to a target with
//     [1:0] != 0 raises a sticky o_fetch_fault and stops fetching until reset
//     (the PC takes the unmasked target). When undefined the low target bits
//     are silently cleared and o_fetch_fault is tied low.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   PC_STEP   PC increment per accepted instruction
//
// Ports
//   i_clk            clock, all state on rising edge
//   i_rst_n          asynchronous active-low reset
//   i_hold           hazard-unit stall (IF/ID will not capture)
//   i_mem_busywait   data-memory stall (IF/ID will not capture)
//   i_branch_taken   redirect request from EX
//   i_branch_target  redirect address
//   o_imem_read      I-mem read request
//   o_imem_addr      I-mem address, stable while read && busywait
//   i_imem_readdata  I-mem data, valid when read && !busywait
//   i_imem_busywait  I-mem not ready
//   o_pc_if          PC of o_instruction_if
//   o_instruction_if fetched instruction, zero when o_if_valid is low
//   o_if_valid       o_pc_if/o_instruction_if describe a real instruction
//   o_fetch_busy     inverse of o_if_valid (IF/ID busywait)
//   o_fetch_fault    misaligned-target fault
// ----------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hold,
  input  logic        i_mem_busywait,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic        o_imem_read,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_readdata,
  input  logic        i_imem_busywait,
  output logic [31:0] o_pc_if,
  output logic [31:0] o_instruction_if,
  output logic        o_if_valid,
  output logic        o_fetch_busy,
  output logic        o_fetch_fault
);

  localparam logic [31:0] PC_STEP_W = 32'(PC_STEP);

  logic [31:0]  r_pc;
  logic [31:0]  r_req_addr;
  logic [31:0]  r_ibuf;

  fetch_state_e w_state;
  logic         w_redirect;
  logic         w_imem_read;
  logic         w_resp;
  logic         w_if_valid;
  logic         w_advance;
  logic         w_misaligned;
  logic [31:0]  w_target;
  logic [31:0]  w_instr;

  if_fetch_fsm u_fsm (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_resp         (w_resp),
    .i_advance      (w_advance),
    .i_branch_taken (i_branch_taken),
    .i_trap         (w_misaligned),
    .o_state        (w_state),
    .o_redirect     (w_redirect)
  );

  assign w_imem_read = (w_state == S_FETCH) || (w_state == S_KILL);
  assign w_resp      = w_imem_read && !i_imem_busywait;

  // A redirect always kills the instruction presented in the same cycle.
  always_comb begin
    w_if_valid = 1'b0;
    case (w_state)
      S_FETCH: w_if_valid = w_resp && !i_branch_taken;
      S_HELD:  w_if_valid = !i_branch_taken;
      default: w_if_valid = 1'b0;
    endcase
  end

  assign w_advance = w_if_valid && !i_hold && !i_mem_busywait && !i_branch_taken;

  always_comb begin
    w_instr = INSTR_BUBBLE;
    if (w_if_valid) begin
      w_instr = (w_state == S_HELD) ? r_ibuf : i_imem_readdata;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_misaligned  = |i_branch_target[1:0];
  // On a trap the faulting address is kept as-is for diagnosis.
  assign w_target      = w_misaligned ? i_branch_target : align_pc(i_branch_target);
  assign o_fetch_fault = (w_state == S_FAULT);
`else
  assign w_misaligned  = 1'b0;
  assign w_target      = align_pc(i_branch_target);
  assign o_fetch_fault = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_ibuf     <= INSTR_BUBBLE;
    end else begin
      // Remember the outstanding address so S_KILL can keep it on the bus
      // after the PC has already moved to a redirect target.
      if (w_state == S_FETCH) begin
        r_req_addr <= r_pc;
      end

      if (w_redirect) begin
        r_pc   <= w_target;
        r_ibuf <= INSTR_BUBBLE;
      end else begin
        if (w_advance) begin
          r_pc <= r_pc + PC_STEP_W;
        end
        if ((w_state == S_FETCH) && w_resp && !w_advance) begin
          r_ibuf <= i_imem_readdata;
        end
      end
    end
  end

  assign o_imem_read      = w_imem_read;
  assign o_imem_addr      = (w_state == S_KILL) ? r_req_addr : r_pc;
  assign o_pc_if          = r_pc;
  assign o_instruction_if = w_instr;
  assign o_if_valid       = w_if_valid;
  assign o_fetch_busy     = !w_if_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        mem_busywait;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic [31:0] pc_if;
  logic [31:0] instruction_if;
  logic        if_valid;
  logic        fetch_busy;
  logic        fetch_fault;

  int n_pass;
  int n_total;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_hold           (hold),
    .i_mem_busywait   (mem_busywait),
    .i_branch_taken   (branch_taken),
    .i_branch_target  (branch_target),
    .o_imem_read      (imem_read),
    .o_imem_addr      (imem_addr),
    .i_imem_readdata  (imem_readdata),
    .i_imem_busywait  (imem_busywait),
    .o_pc_if          (pc_if),
    .o_instruction_if (instruction_if),
    .o_if_valid       (if_valid),
    .o_fetch_busy     (fetch_busy),
    .o_fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the address; outside a completed
  // read the bus carries garbage so a buffered word cannot be faked by it.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] r;
    r = (a ^ 32'h5A5A_0F0F) + {a[15:0], a[31:16]} + 32'h0101_0000;
    return r;
  endfunction

  assign imem_readdata = (imem_read && !imem_busywait) ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_pc_q.push_back(pc);
    exp_ins_q.push_back(mem_word(pc));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0; mem_busywait = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; imem_busywait = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    n_total++; if (imem_read !== 1'b0) $display("FAIL rst_read: got %b expected 0", imem_read); else n_pass++;
    n_total++; if (pc_if !== 32'h0) $display("FAIL rst_pc: got %h expected 00000000", pc_if); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h expected 00000000", imem_addr); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", if_valid); else n_pass++;
    n_total++; if (fetch_busy !== 1'b1) $display("FAIL rst_busy: got %b expected 1", fetch_busy); else n_pass++;
    n_total++; if (instruction_if !== 32'h0) $display("FAIL rst_instr: got %h expected 00000000", instruction_if); else n_pass++;
    n_total++; if (fetch_fault !== 1'b0) $display("FAIL rst_fault: got %b expected 0", fetch_fault); else n_pass++;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (imem_read !== 1'b0) $display("FAIL idle_read: got %b expected 0", imem_read); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (imem_read !== 1'b1) $display("FAIL first_read: got %b expected 1", imem_read); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL first_addr: got %h expected 00000000", imem_addr); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL first_miss_valid: got %b expected 0", if_valid); else n_pass++;
  endtask

  task automatic test_hit_stream();
    logic [31:0] e_pc, e_ins;
    for (int i = 0; i < 4; i++) begin
      tick();
      imem_busywait = 1'b0;
      push_exp(32'(4 * i));
      @(negedge clk);
      e_pc = exp_pc_q.pop_front(); e_ins = exp_ins_q.pop_front();
      n_total++; if (if_valid !== 1'b1) $display("FAIL hit_valid[%0d]: got %b expected 1", i, if_valid); else n_pass++;
      n_total++; if (pc_if !== e_pc) $display("FAIL hit_pc[%0d]: got %h expected %h", i, pc_if, e_pc); else n_pass++;
      n_total++; if (instruction_if !== e_ins) $display("FAIL hit_instr[%0d]: got %h expected %h", i, instruction_if, e_ins); else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] e_pc, e_ins;
    tick();
    hold = 1'b1;
    push_exp(32'h10);
    @(negedge clk);
    n_total++; if (if_valid !== 1'b1) $display("FAIL stall0_valid: got %b expected 1", if_valid); else n_pass++;
    n_total++; if (pc_if !== 32'h10) $display("FAIL stall0_pc: got %h expected 00000010", pc_if); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (imem_read !== 1'b0) $display("FAIL stall1_read: got %b expected 0", imem_read); else n_pass++;
    n_total++; if (instruction_if !== mem_word(32'h10)) $display("FAIL stall1_instr: got %h expected %h", instruction_if, mem_word(32'h10)); else n_pass++;
    n_total++; if (pc_if !== 32'h10) $display("FAIL stall1_pc: got %h expected 00000010", pc_if); else n_pass++;
    tick();
    hold = 1'b0;
    @(negedge clk);
    e_pc = exp_pc_q.pop_front(); e_ins = exp_ins_q.pop_front();
    n_total++; if (imem_read !== 1'b0) $display("FAIL stall_rel_read: got %b expected 0", imem_read); else n_pass++;
    n_total++; if (if_valid !== 1'b1) $display("FAIL stall_rel_valid: got %b expected 1", if_valid); else n_pass++;
    n_total++; if (pc_if !== e_pc) $display("FAIL stall_rel_pc: got %h expected %h", pc_if, e_pc); else n_pass++;
    n_total++; if (instruction_if !== e_ins) $display("FAIL stall_rel_instr: got %h expected %h", instruction_if, e_ins); else n_pass++;
    tick();
    push_exp(32'h14);
    @(negedge clk);
    e_pc = exp_pc_q.pop_front(); e_ins = exp_ins_q.pop_front();
    n_total++; if (imem_addr !== 32'h14) $display("FAIL stall_next_addr: got %h expected 00000014", imem_addr); else n_pass++;
    n_total++; if (pc_if !== e_pc) $display("FAIL stall_next_pc: got %h expected %h", pc_if, e_pc); else n_pass++;
    n_total++; if (instruction_if !== e_ins) $display("FAIL stall_next_instr: got %h expected %h", instruction_if, e_ins); else n_pass++;
  endtask

  task automatic test_miss();
    logic [31:0] e_pc, e_ins;
    tick();
    branch_taken = 1'b1; branch_target = 32'h8;
    @(negedge clk);
    n_total++; if (if_valid !== 1'b0) $display("FAIL redir_hit_valid: got %b expected 0", if_valid); else n_pass++;
    n_total++; if (fetch_busy !== 1'b1) $display("FAIL redir_hit_busy: got %b expected 1", fetch_busy); else n_pass++;
    tick();
    branch_taken = 1'b0;
    imem_busywait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      n_total++; if (imem_addr !== 32'h8) $display("FAIL miss_addr[%0d]: got %h expected 00000008", i, imem_addr); else n_pass++;
      n_total++; if (if_valid !== 1'b0) $display("FAIL miss_valid[%0d]: got %b expected 0", i, if_valid); else n_pass++;
    end
    tick();
    imem_busywait = 1'b0;
    push_exp(32'h8);
    @(negedge clk);
    e_pc = exp_pc_q.pop_front(); e_ins = exp_ins_q.pop_front();
    n_total++; if (if_valid !== 1'b1) $display("FAIL miss_done_valid: got %b expected 1", if_valid); else n_pass++;
    n_total++; if (pc_if !== e_pc) $display("FAIL miss_done_pc: got %h expected %h", pc_if, e_pc); else n_pass++;
    n_total++; if (instruction_if !== e_ins) $display("FAIL miss_done_instr: got %h expected %h", instruction_if, e_ins); else n_pass++;
  endtask

  task automatic test_redirect_miss();
    logic [31:0] e_pc, e_ins;
    for (int i = 0; i < 5; i++) begin
      tick();
      push_exp(32'h0C + 32'(4 * i));
      @(negedge clk);
      e_pc = exp_pc_q.pop_front(); e_ins = exp_ins_q.pop_front();
      n_total++; if (pc_if !== e_pc) $display("FAIL b2b_pc[%0d]: got %h expected %h", i, pc_if, e_pc); else n_pass++;
      n_total++; if (instruction_if !== e_ins) $display("FAIL b2b_instr[%0d]: got %h expected %h", i, instruction_if, e_ins); else n_pass++;
    end
    tick();
    imem_busywait = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h100;
    @(negedge clk);
    n_total++; if (imem_addr !== 32'h20) $display("FAIL kill0_addr: got %h expected 00000020", imem_addr); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL kill0_valid: got %b expected 0", if_valid); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      n_total++; if (imem_addr !== 32'h20) $display("FAIL kill_addr[%0d]: got %h expected 00000020", i, imem_addr); else n_pass++;
      n_total++; if (imem_read !== 1'b1) $display("FAIL kill_read[%0d]: got %b expected 1", i, imem_read); else n_pass++;
      n_total++; if (pc_if !== 32'h100) $display("FAIL kill_pc[%0d]: got %h expected 00000100", i, pc_if); else n_pass++;
    end
    tick();
    branch_taken = 1'b0;
    imem_busywait = 1'b0;
    @(negedge clk);
    n_total++; if (imem_addr !== 32'h20) $display("FAIL kill_resp_addr: got %h expected 00000020", imem_addr); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL kill_resp_valid: got %b expected 0", if_valid); else n_pass++;
    n_total++; if (instruction_if !== 32'h0) $display("FAIL kill_resp_instr: got %h expected 00000000", instruction_if); else n_pass++;
    tick();
    push_exp(32'h100);
    @(negedge clk);
    e_pc = exp_pc_q.pop_front(); e_ins = exp_ins_q.pop_front();
    n_total++; if (imem_addr !== 32'h100) $display("FAIL target_addr: got %h expected 00000100", imem_addr); else n_pass++;
    n_total++; if (pc_if !== e_pc) $display("FAIL target_pc: got %h expected %h", pc_if, e_pc); else n_pass++;
    n_total++; if (instruction_if !== e_ins) $display("FAIL target_instr: got %h expected %h", instruction_if, e_ins); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] e_pc, e_ins;
    tick();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    n_total++; if (if_valid !== 1'b0) $display("FAIL wrap_redir_valid: got %b expected 0", if_valid); else n_pass++;
    tick();
    branch_taken = 1'b0;
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      e_pc = exp_pc_q.pop_front(); e_ins = exp_ins_q.pop_front();
      n_total++; if (pc_if !== e_pc) $display("FAIL wrap_pc[%0d]: got %h expected %h", i, pc_if, e_pc); else n_pass++;
      n_total++; if (instruction_if !== e_ins) $display("FAIL wrap_instr[%0d]: got %h expected %h", i, instruction_if, e_ins); else n_pass++;
    end
  endtask

  task automatic test_misalign();
    logic [31:0] e_pc, e_ins;
    tick();
    branch_taken = 1'b1; branch_target = 32'h0000_0102;
    @(negedge clk);
    n_total++; if (fetch_fault !== 1'b0) $display("FAIL mis_fault_early: got %b expected 0", fetch_fault); else n_pass++;
    tick();
    branch_taken = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    @(negedge clk);
    n_total++; if (fetch_fault !== 1'b1) $display("FAIL mis_fault: got %b expected 1", fetch_fault); else n_pass++;
    n_total++; if (imem_read !== 1'b0) $display("FAIL mis_read: got %b expected 0", imem_read); else n_pass++;
    n_total++; if (pc_if !== 32'h102) $display("FAIL mis_pc: got %h expected 00000102", pc_if); else n_pass++;
    tick();
    branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    n_total++; if (fetch_fault !== 1'b1) $display("FAIL mis_sticky: got %b expected 1", fetch_fault); else n_pass++;
    n_total++; if (imem_read !== 1'b0) $display("FAIL mis_sticky_read: got %b expected 0", imem_read); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL mis_sticky_valid: got %b expected 0", if_valid); else n_pass++;
`else
    push_exp(32'h100);
    @(negedge clk);
    e_pc = exp_pc_q.pop_front(); e_ins = exp_ins_q.pop_front();
    n_total++; if (imem_addr !== 32'h100) $display("FAIL mis_addr: got %h expected 00000100", imem_addr); else n_pass++;
    n_total++; if (pc_if !== e_pc) $display("FAIL mis_pc: got %h expected %h", pc_if, e_pc); else n_pass++;
    n_total++; if (instruction_if !== e_ins) $display("FAIL mis_instr: got %h expected %h", instruction_if, e_ins); else n_pass++;
    n_total++; if (fetch_fault !== 1'b0) $display("FAIL mis_fault: got %b expected 0", fetch_fault); else n_pass++;
`endif
  endtask

  task automatic test_reset_midmiss();
    tick();
    imem_busywait = 1'b1;
    @(negedge clk);
`ifndef FETCH_MISALIGN_TRAP_EN
    n_total++; if (imem_read !== 1'b1) $display("FAIL midmiss_read: got %b expected 1", imem_read); else n_pass++;
    n_total++; if (imem_addr !== 32'h104) $display("FAIL midmiss_addr: got %h expected 00000104", imem_addr); else n_pass++;
`endif
    #1;
    rst_n = 1'b0;
    #1;
    n_total++; if (imem_read !== 1'b0) $display("FAIL arst_read: got %b expected 0", imem_read); else n_pass++;
    n_total++; if (pc_if !== 32'h0) $display("FAIL arst_pc: got %h expected 00000000", pc_if); else n_pass++;
    n_total++; if (fetch_fault !== 1'b0) $display("FAIL arst_fault: got %b expected 0", fetch_fault); else n_pass++;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (imem_read !== 1'b0) $display("FAIL arst_idle_read: got %b expected 0", imem_read); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (imem_read !== 1'b1) $display("FAIL arst_restart_read: got %b expected 1", imem_read); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL arst_restart_addr: got %h expected 00000000", imem_addr); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_hit_stream();
    test_stall();
    test_miss();
    test_redirect_miss();
    test_wrap();
    test_misalign();
    test_reset_midmiss();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
